// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: per-channel FSM encoding and pointer sizing.
// No logic; imported by the controller and its picker.
// No flow control of its own.
package data_mem_ctrl_pkg;

    localparam int DATA_MEM_CTRL_STATE_BITS = 3;

    typedef enum logic [DATA_MEM_CTRL_STATE_BITS-1:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } chan_state_t;

    // Consumer index width, never narrower than one bit.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_picker.sv
// Find-first-set over pending consumers that are neither served nor already claimed, from a rotating start.
// Purely combinational, zero latency.
// No backpressure; a disabled picker claims nothing and forwards the claimed mask unchanged.
module data_mem_ctrl_picker #(
    parameter int NUM_CONSUMERS = 4,
    parameter int PTR_W         = 2
) (
    input  logic                     en,
    input  logic [NUM_CONSUMERS-1:0] pending,
    input  logic [NUM_CONSUMERS-1:0] serving,
    input  logic [NUM_CONSUMERS-1:0] claimed_in,
    input  logic [PTR_W-1:0]         offset,
    output logic                     found,
    output logic [PTR_W-1:0]         idx,
    output logic [NUM_CONSUMERS-1:0] claimed_out
);

    int               cand;
    logic [PTR_W-1:0] cand_p;

    always_comb begin
        found       = 1'b0;
        idx         = '0;
        claimed_out = claimed_in;
        cand        = 0;
        cand_p      = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = int'(offset) + k;
            if (cand >= NUM_CONSUMERS) cand = cand - NUM_CONSUMERS;
            cand_p = PTR_W'(cand);
            if (en && !found && pending[cand_p] && !serving[cand_p] && !claimed_in[cand_p]) begin
                found               = 1'b1;
                idx                 = cand_p;
                claimed_out[cand_p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Arbitrates NUM_CONSUMERS LSU read/write requesters onto NUM_CHANNELS memory channels; DATA_MEM_CTRL_RR_EN selects round-robin over fixed priority.
// Request to mem valid 1 cycle; mem ready to consumer ready 1 cycle; 1-cycle IDLE gap per channel after release.
// Memory valid held until mem ready; consumer ready/data held until the consumer drops its valid.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int PTR_W = ptr_bits(NUM_CONSUMERS);

    chan_state_t              state     [NUM_CHANNELS];
    logic [PTR_W-1:0]         chan_cons [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] serving;
    logic [NUM_CONSUMERS-1:0] pending;
    logic [NUM_CHANNELS-1:0]  grant_vld;
    logic [PTR_W-1:0]         grant_idx [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] claim_chain [NUM_CHANNELS+1];
    logic [PTR_W-1:0]         search_base;

    assign pending        = consumer_read_valid | consumer_write_valid;
    assign claim_chain[0] = '0;

    // Lower channels claim first; the chained mask hides their picks from higher channels.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pick
        data_mem_ctrl_picker #(
            .NUM_CONSUMERS (NUM_CONSUMERS),
            .PTR_W         (PTR_W)
        ) u_picker (
            .en          (state[g] == IDLE),
            .pending     (pending),
            .serving     (serving),
            .claimed_in  (claim_chain[g]),
            .offset      (search_base),
            .found       (grant_vld[g]),
            .idx         (grant_idx[g]),
            .claimed_out (claim_chain[g+1])
        );
    end

`ifdef DATA_MEM_CTRL_RR_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_nxt;
    logic [PTR_W-1:0] hi_idx;
    logic             any_grant;

    always_comb begin
        any_grant = 1'b0;
        hi_idx    = '0;
        rr_nxt    = rr_ptr;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (grant_vld[ch]) begin
                any_grant = 1'b1;
                if (grant_idx[ch] >= hi_idx) hi_idx = grant_idx[ch];
            end
        end
        if (any_grant)
            rr_nxt = (hi_idx == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : hi_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr <= '0;
        else        rr_ptr <= rr_nxt;
    end

    assign search_base = rr_ptr;
`else
    assign search_base = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]     <= IDLE;
                chan_cons[ch] <= '0;
            end
            serving              <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state[ch])
                    IDLE: begin
                        if (grant_vld[ch]) begin
                            chan_cons[ch] <= grant_idx[ch];
                            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                                if (grant_idx[ch] == PTR_W'(c)) begin
                                    serving[c] <= 1'b1;
                                    // Read wins when both are pending; the write is picked up on a later grant.
                                    if (consumer_read_valid[c]) begin
                                        mem_read_valid[ch] <= 1'b1;
                                        mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                            consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
                                        state[ch] <= READ_WAIT;
                                    end else begin
                                        mem_write_valid[ch] <= 1'b1;
                                        mem_write_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                            consumer_write_address[c*ADDR_BITS +: ADDR_BITS];
                                        mem_write_data[ch*DATA_BITS +: DATA_BITS] <=
                                            consumer_write_data[c*DATA_BITS +: DATA_BITS];
                                        state[ch] <= WRITE_WAIT;
                                    end
                                end
                            end
                        end
                    end
                    READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch] <= 1'b0;
                            state[ch]          <= READ_RELAY;
                            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                                if (chan_cons[ch] == PTR_W'(c)) begin
                                    consumer_read_ready[c] <= 1'b1;
                                    consumer_read_data[c*DATA_BITS +: DATA_BITS] <=
                                        mem_read_data[ch*DATA_BITS +: DATA_BITS];
                                end
                            end
                        end
                    end
                    WRITE_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch] <= 1'b0;
                            state[ch]           <= WRITE_RELAY;
                            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                                if (chan_cons[ch] == PTR_W'(c)) consumer_write_ready[c] <= 1'b1;
                            end
                        end
                    end
                    READ_RELAY: begin
                        for (int c = 0; c < NUM_CONSUMERS; c++) begin
                            if (chan_cons[ch] == PTR_W'(c) && !consumer_read_valid[c]) begin
                                consumer_read_ready[c] <= 1'b0;
                                serving[c]             <= 1'b0;
                                state[ch]              <= IDLE;
                            end
                        end
                    end
                    WRITE_RELAY: begin
                        for (int c = 0; c < NUM_CONSUMERS; c++) begin
                            if (chan_cons[ch] == PTR_W'(c) && !consumer_write_valid[c]) begin
                                consumer_write_ready[c] <= 1'b0;
                                serving[c]              <= 1'b0;
                                state[ch]               <= IDLE;
                            end
                        end
                    end
                    default: state[ch] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one single-channel and one dual-channel instance, each against a registered-ready memory model.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single-channel instance
    logic [3:0]  c1_rvld, c1_rrdy, c1_wvld, c1_wrdy;
    logic [31:0] c1_raddr, c1_rdat, c1_waddr, c1_wdat;
    logic        m1_rvld, m1_rrdy, m1_wvld, m1_wrdy, mdl1_rrdy, inject_rrdy;
    logic [7:0]  m1_raddr, m1_rdat, m1_waddr, m1_wdat;
    logic [7:0]  mem1 [256];

    assign m1_rrdy = mdl1_rrdy | inject_rrdy;

    data_mem_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c1_rvld), .consumer_read_address(c1_raddr),
        .consumer_read_ready(c1_rrdy), .consumer_read_data(c1_rdat),
        .consumer_write_valid(c1_wvld), .consumer_write_address(c1_waddr),
        .consumer_write_data(c1_wdat), .consumer_write_ready(c1_wrdy),
        .mem_read_valid(m1_rvld), .mem_read_address(m1_raddr),
        .mem_read_ready(m1_rrdy), .mem_read_data(m1_rdat),
        .mem_write_valid(m1_wvld), .mem_write_address(m1_waddr),
        .mem_write_data(m1_wdat), .mem_write_ready(m1_wrdy)
    );

    // Memory model: ready is a one-cycle pulse registered from valid; contents default to ~addr.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl1_rrdy <= 1'b0;
            m1_wrdy   <= 1'b0;
            m1_rdat   <= 8'h00;
            for (int i = 0; i < 256; i++) mem1[i] <= 8'(~i);
            mem1[8'h10] <= 8'h5A;
        end else begin
            mdl1_rrdy <= m1_rvld & ~mdl1_rrdy;
            m1_rdat   <= mem1[m1_raddr];
            m1_wrdy   <= m1_wvld & ~m1_wrdy;
            if (m1_wvld && !m1_wrdy) mem1[m1_waddr] <= m1_wdat;
        end
    end

    // Dual-channel instance, read-only traffic
    logic [3:0]  c2_rvld, c2_rrdy, c2_wvld, c2_wrdy;
    logic [31:0] c2_raddr, c2_rdat, c2_waddr, c2_wdat;
    logic [1:0]  m2_rvld, m2_rrdy, m2_wvld, m2_wrdy;
    logic [15:0] m2_raddr, m2_rdat, m2_waddr, m2_wdat;

    assign m2_wrdy = 2'b00;

    data_mem_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c2_rvld), .consumer_read_address(c2_raddr),
        .consumer_read_ready(c2_rrdy), .consumer_read_data(c2_rdat),
        .consumer_write_valid(c2_wvld), .consumer_write_address(c2_waddr),
        .consumer_write_data(c2_wdat), .consumer_write_ready(c2_wrdy),
        .mem_read_valid(m2_rvld), .mem_read_address(m2_raddr),
        .mem_read_ready(m2_rrdy), .mem_read_data(m2_rdat),
        .mem_write_valid(m2_wvld), .mem_write_address(m2_waddr),
        .mem_write_data(m2_wdat), .mem_write_ready(m2_wrdy)
    );

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m2_rrdy <= 2'b00;
            m2_rdat <= 16'h0000;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                m2_rrdy[ch]         <= m2_rvld[ch] & ~m2_rrdy[ch];
                m2_rdat[ch*8 +: 8]  <= ~m2_raddr[ch*8 +: 8];
            end
        end
    end

    // Both channels active must always mean two different consumers (distinct addresses here).
    always @(negedge clk) begin
        if (reset && m2_rvld == 2'b11)
            check("dual_owner_distinct", 32'(m2_raddr[7:0] != m2_raddr[15:8]), 32'd1);
    end

    typedef struct {
        int         cons;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];
    int   exp_order [5];

    task automatic do_xfer(input vec_t v);
        int lat;
        if (v.wr) begin
            c1_wvld[v.cons]          = 1'b1;
            c1_waddr[v.cons*8 +: 8]  = v.addr;
            c1_wdat[v.cons*8 +: 8]   = v.wdat;
        end else begin
            c1_rvld[v.cons]          = 1'b1;
            c1_raddr[v.cons*8 +: 8]  = v.addr;
        end
        @(negedge clk);
        if (v.wr) begin
            check("wr_mem_valid", 32'(m1_wvld), 32'd1);
            check("wr_mem_addr", 32'(m1_waddr), 32'(v.addr));
            check("wr_mem_data", 32'(m1_wdat), 32'(v.wdat));
        end else begin
            check("rd_mem_valid", 32'(m1_rvld), 32'd1);
            check("rd_mem_addr", 32'(m1_raddr), 32'(v.addr));
        end
        lat = 1;
        while (!(v.wr ? c1_wrdy[v.cons] : c1_rrdy[v.cons]) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("round_trip", 32'(lat), 32'd3);
        if (v.wr) begin
            check("wr_mem_content", 32'(mem1[v.addr]), 32'(v.exp));
            check("wr_mem_valid_drop", 32'(m1_wvld), 32'd0);
        end else begin
            check("rd_data", 32'(c1_rdat[v.cons*8 +: 8]), 32'(v.exp));
            check("rd_mem_valid_drop", 32'(m1_rvld), 32'd0);
        end
        @(negedge clk);
        check("ready_held", 32'(v.wr ? c1_wrdy[v.cons] : c1_rrdy[v.cons]), 32'd1);
        if (v.wr) c1_wvld[v.cons] = 1'b0;
        else      c1_rvld[v.cons] = 1'b0;
        @(negedge clk);
        check("ready_release", 32'(v.wr ? c1_wrdy[v.cons] : c1_rrdy[v.cons]), 32'd0);
        @(negedge clk);
    endtask

    task automatic serve_next(output int who);
        int cnt;
        cnt = 0;
        who = -1;
        while (c1_rrdy == 4'b0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (c1_rrdy != 4'b0) begin
            for (int i = 3; i >= 0; i--) if (c1_rrdy[i]) who = i;
            check("ctn_onehot", 32'($countones(c1_rrdy)), 32'd1);
            check("ctn_data", 32'(c1_rdat[who*8 +: 8]), 32'(8'(8'hBF - who)));
            c1_rvld[who] = 1'b0;
            @(negedge clk);
            check("ctn_release", 32'(c1_rrdy), 32'd0);
        end
    endtask

    initial begin
        int who;
        int cnt;

        vecs[0] = '{2, 1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[1] = '{0, 1'b1, 8'h20, 8'hC3, 8'hC3};
        vecs[2] = '{0, 1'b0, 8'h20, 8'h00, 8'hC3};
        vecs[3] = '{3, 1'b0, 8'h33, 8'h00, 8'hCC};
        vecs[4] = '{1, 1'b1, 8'hFF, 8'h00, 8'h00};
        vecs[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[6] = '{3, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[7] = '{2, 1'b1, 8'h7E, 8'h3C, 8'h3C};
        vecs[8] = '{2, 1'b0, 8'h7E, 8'h00, 8'h3C};
`ifdef DATA_MEM_CTRL_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 2, 0, 3};
`endif

        reset = 1'b0;
        inject_rrdy = 1'b0;
        c1_rvld = '0; c1_raddr = '0; c1_wvld = '0; c1_waddr = '0; c1_wdat = '0;
        c2_rvld = '0; c2_raddr = '0; c2_wvld = '0; c2_waddr = '0; c2_wdat = '0;

        repeat (2) @(negedge clk);
        check("rst_mem_rvld", 32'(m1_rvld), 32'd0);
        check("rst_mem_wvld", 32'(m1_wvld), 32'd0);
        check("rst_cons_rrdy", 32'(c1_rrdy), 32'd0);
        check("rst_cons_wrdy", 32'(c1_wrdy), 32'd0);
        check("rst_cons_rdat", c1_rdat, 32'd0);
        check("rst_dual_rvld", 32'(m2_rvld), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) do_xfer(vecs[i]);

        // All four contend for one channel; 0 re-requests once 3 is the only one left waiting.
        c1_raddr = 32'h43424140;
        c1_rvld  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            serve_next(who);
            check("ctn_order", 32'(who), 32'(exp_order[k]));
            if (k == 2) c1_rvld[0] = 1'b1;
        end
        c1_rvld = 4'h0;
        repeat (2) @(negedge clk);

        // Two channels: 0/1 granted together, then 2/3.
        c2_raddr = 32'h63626160;
        c2_rvld  = 4'hF;
        @(negedge clk);
        check("dual_grant_vld", 32'(m2_rvld), 32'h3);
        check("dual_grant_addr", 32'(m2_raddr), 32'h6160);
        cnt = 0;
        while (c2_rrdy == 4'b0 && cnt < 20) begin @(negedge clk); cnt++; end
        check("dual_ready_01", 32'(c2_rrdy), 32'h3);
        check("dual_data_01", 32'(c2_rdat[15:0]), 32'h9E9F);
        c2_rvld[1:0] = 2'b00;
        @(negedge clk);
        check("dual_release_01", 32'(c2_rrdy), 32'h0);
        @(negedge clk);
        check("dual_grant2_vld", 32'(m2_rvld), 32'h3);
        check("dual_grant2_addr", 32'(m2_raddr), 32'h6362);
        cnt = 0;
        while (c2_rrdy == 4'b0 && cnt < 20) begin @(negedge clk); cnt++; end
        check("dual_ready_23", 32'(c2_rrdy), 32'hC);
        check("dual_data_23", 32'(c2_rdat[31:16]), 32'h9C9D);
        c2_rvld = 4'h0;
        repeat (2) @(negedge clk);

        // Reset while a read is outstanding.
        c1_rvld[1]      = 1'b1;
        c1_raddr[15:8]  = 8'h10;
        @(negedge clk);
        check("mid_rst_wait", 32'(m1_rvld), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_mem_rvld", 32'(m1_rvld), 32'd0);
        check("mid_rst_mem_raddr", 32'(m1_raddr), 32'd0);
        check("mid_rst_mem_waddr", 32'(m1_waddr), 32'd0);
        check("mid_rst_mem_wdat", 32'(m1_wdat), 32'd0);
        check("mid_rst_cons_rrdy", 32'(c1_rrdy), 32'd0);
        check("mid_rst_cons_rdat", c1_rdat, 32'd0);
        check("mid_rst_dual_rdat", c2_rdat, 32'd0);
        c1_rvld = 4'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        inject_rrdy = 1'b1;
        @(negedge clk);
        inject_rrdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("late_ack_ignored", 32'(c1_rrdy), 32'd0);
            check("late_ack_mem_idle", 32'(m1_rvld), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory controller between the per-thread load/store units of the GPU cores and the external flattened data-memory interface. It arbitrates `NUM_CONSUMERS` independent read/write requesters onto `NUM_CHANNELS` parallel memory channels, each running its own transaction state machine. It generalises the single-port `data_mem_read_*` / `data_mem_write_*` valid/ready interface of `top` to N channels with fair arbitration.

## Interface
- `ADDR_BITS`, 8, address width per request
- `DATA_BITS`, 8, data width per request
- `NUM_CONSUMERS`, 4, requester (LSU) count, ≥1
- `NUM_CHANNELS`, 1, memory channels, 1..`NUM_CONSUMERS`
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `consumer_read_valid`  in  `NUM_CONSUMERS`  per-consumer read request
- `consumer_read_address`  in  `NUM_CONSUMERS*ADDR_BITS`  packed, consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
- `consumer_read_ready`  out  `NUM_CONSUMERS`  read data valid and held
- `consumer_read_data`  out  `NUM_CONSUMERS*DATA_BITS`  packed read data
- `consumer_write_valid`  in  `NUM_CONSUMERS`  per-consumer write request
- `consumer_write_address`  in  `NUM_CONSUMERS*ADDR_BITS`  packed
- `consumer_write_data`  in  `NUM_CONSUMERS*DATA_BITS`  packed
- `consumer_write_ready`  out  `NUM_CONSUMERS`  write done and held
- `mem_read_valid` / `mem_write_valid`  out  `NUM_CHANNELS`  per-channel request
- `mem_read_address` / `mem_write_address`  out  `NUM_CHANNELS*ADDR_BITS`  packed
- `mem_write_data`  out  `NUM_CHANNELS*DATA_BITS`  packed
- `mem_read_ready` / `mem_write_ready`  in  `NUM_CHANNELS`  memory acknowledge
- `mem_read_data`  in  `NUM_CHANNELS*DATA_BITS`  packed, valid when `mem_read_ready` is high

## Operation
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- A `serving` mask of `NUM_CONSUMERS` bits marks consumers owned by a channel. No consumer is ever owned by two channels.
- **IDLE:** the channel scans for a consumer that has a pending valid and is not in `serving`.
  - Channels pick in ascending index within one cycle. A consumer claimed by a lower channel is invisible to higher channels in that same cycle.
  - If a claimed consumer has both valids high, the read is served first. The write is served on a later grant.
  - On a grant, the channel latches the consumer index, address and data. It sets the `serving` bit, raises the matching `mem_*_valid`, and moves to *_WAIT.
- **READ_WAIT:** `mem_read_valid` is held high until `mem_read_ready` is sampled high. On that edge:
  - `mem_read_data` is captured into `consumer_read_data[c]`.
  - `consumer_read_ready[c]` is set and `mem_read_valid` is cleared.
  - The FSM moves to READ_RELAY.
- **WRITE_WAIT:** the same handshake using `mem_write_*`, setting `consumer_write_ready[c]`. The FSM moves to WRITE_RELAY.
- **\*_RELAY:** the consumer's ready and data stay held until the consumer drops the corresponding valid. On that edge:
  - the ready is cleared and the `serving` bit is cleared;
  - the FSM returns to IDLE.
- Address and data pass through unmodified. There is no width conversion.

## Timing
- Reset (`reset`=0, asynchronous) clears immediately:
  - all `mem_*_valid`, `mem_*_address`, `mem_write_data`;
  - all `consumer_*_ready`, `consumer_read_data`;
  - the `serving` mask, the round-robin pointer, and all FSMs to IDLE.
- Reset mid-transaction abandons the outstanding memory access. No acknowledge is delivered after release.
- Consumer valid high before edge t → `mem_*_valid` high after edge t (1 cycle).
- `mem_*_ready` high at edge t → consumer ready high after edge t. Memory valid drops after that same edge.
- Consumer valid low at edge t → ready low after edge t. The channel is re-grantable at edge t+1, giving a 1-cycle minimum IDLE gap per channel.
- Against the bench memory model (ready registered from valid), read round trip = 3 cycles from request to `consumer_read_ready`.
- `mem_*_ready` arriving while a channel is not in *_WAIT is ignored.

## Configuration
- `DATA_MEM_CTRL_RR_EN` defined:
  - a shared pointer `rr_ptr` (width `$clog2(NUM_CONSUMERS)`, min 1) sets the search start;
  - the search wraps modulo `NUM_CONSUMERS`;
  - after any grant cycle, `rr_ptr` = (highest-indexed consumer granted that cycle + 1) mod `NUM_CONSUMERS`.
- Undefined: fixed priority. Every channel searches from consumer 0 upward, and `rr_ptr` logic is absent.

## Structure
- Package `data_mem_ctrl_pkg`:
  - channel state enum: IDLE=0, READ_WAIT=1, WRITE_WAIT=2, READ_RELAY=3, WRITE_RELAY=4; 3 bits;
  - `DATA_MEM_CTRL_STATE_BITS` constant.
- Sub-module `data_mem_ctrl_picker`: combinational find-first-set over (pending & ~serving), starting at a rotation offset. It is instantiated once per channel, chained by a claimed mask.

## Test plan
- **Single read:** `NUM_CHANNELS`=1; consumer 2 reads addr 0x10, memory holds 0x5A → `mem_read_valid`=1 with addr 0x10 one cycle later; `consumer_read_ready[2]`=1 with data 0x5A; ready held until valid dropped, then cleared the next edge.
- **Write:** consumer 0 writes 0xC3 to 0x20 → `mem_write_valid`=1 with addr 0x20, data 0xC3; memory location 0x20 = 0xC3 after the handshake; `consumer_write_ready[0]` set.
- **Contention, RR on:** all 4 consumers read simultaneously, 1 channel → grant order 0,1,2,3. Then 0 re-requests while 3 is pending → 3 served before 0.
- **Contention, RR off:** same stimulus → consumer 0 is always served first whenever it is pending.
- **Two channels:** 4 consumers read simultaneously → consumers 0 and 1 are granted on the same edge on channels 0 and 1; no consumer is ever on two channels.
- **Reset mid-transaction:** `reset`=0 during READ_WAIT → all outputs 0 immediately; a late `mem_read_ready`=1 after release produces no consumer ready.
